// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: segment/anode idle levels
// and the hex-to-segment table (g..a, active-high).
package seg7_pkg;

   localparam logic [7:0]  SEG_OFF = 8'hFF;
   localparam logic [15:0] AN_OFF  = 16'hFFFF;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// CPU-side load bus of the scanner: display contents, live controls and the
// load/ack handshake.
interface seg7_scan_ctrl_if #(
   parameter int NDIGITS  = 8,
   parameter int PWM_BITS = 4
) ();

   logic [4*NDIGITS-1:0] data_in;
   logic [NDIGITS-1:0]   dp_in;
   logic [NDIGITS-1:0]   blank_in;
   logic [NDIGITS-1:0]   blink_in;
   logic                 lz_en;
   logic [PWM_BITS-1:0]  brightness;
   logic                 load;
   logic                 load_ack;

   modport master (
      output data_in, dp_in, blank_in, blink_in, lz_en, brightness, load,
      input  load_ack
   );

   modport slave (
      input  data_in, dp_in, blank_in, blink_in, lz_en, brightness, load,
      output load_ack
   );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to seven-segment pattern (g..a, active-high).
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with PWM dimming, blank slot, blink,
// leading-zero suppression and a frame-synchronous double-buffered load.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NDIGITS      = 8,
   parameter int PWM_BITS     = 4,
   parameter int BLINK_FRAMES = 625
) (
   input  logic               led_clk,
   input  logic               rst,
   seg7_scan_ctrl_if.slave    bus,
   output logic               frame_start,
   output logic [NDIGITS-1:0] AN,
   output logic [7:0]         SEG
);

   localparam int SEL_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SEL_W-1:0]    SEL_LAST  = SEL_W'(NDIGITS - 1);
   localparam logic [PWM_BITS-1:0] DWELL_MAX = '1;
   localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [PWM_BITS-1:0]  dwell_q, dwell_d;
   logic [4*NDIGITS-1:0] stg_data_q, stg_data_d, act_data_q, act_data_d;
   logic [NDIGITS-1:0]   stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
   logic [NDIGITS-1:0]   stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
   logic [NDIGITS-1:0]   stg_blink_q, stg_blink_d, act_blink_q, act_blink_d;
   logic                 pending_q, pending_d;
   logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
   logic                 phase_q, phase_d;
   logic [NDIGITS-1:0]   an_q, an_d;
   logic [7:0]           seg_q, seg_d;
   logic                 fs_q, fs_d;
   logic                 ack_q, ack_d;

   logic                 boundary;
   logic                 commit;
   logic                 lz_run;
   logic [NDIGITS-1:0]   sup;
   logic [3:0]           cur_nib;
   logic                 cur_dp;
   logic                 cur_dark;
   logic                 digit_on;
   logic [6:0]           cur_pat;

   seg7_hex_decode u_dec (
      .nib_i (cur_nib),
      .seg_o (cur_pat)
   );

   // Zero run from the most significant digit; digit 0 always stays visible.
   always_comb begin
      sup    = '0;
      lz_run = bus.lz_en;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         lz_run = lz_run && (act_data_q[4*i +: 4] == 4'h0);
         sup[i] = lz_run && (i != 0);
      end
   end

   always_comb begin
      cur_nib  = 4'h0;
      cur_dp   = 1'b0;
      cur_dark = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (SEL_W'(i) == sel_q) begin
            cur_nib  = act_data_q[4*i +: 4];
            cur_dp   = act_dp_q[i];
            cur_dark = act_blank_q[i] | (phase_q & act_blink_q[i]) | sup[i];
         end
      end
   end

   assign digit_on = (dwell_q != '0) && (dwell_q <= bus.brightness) && !cur_dark;
   assign boundary = (sel_q == SEL_LAST) && (dwell_q == DWELL_MAX);
   assign commit   = boundary && (pending_q || bus.load);

   always_comb begin
      dwell_d     = dwell_q + PWM_BITS'(1);
      sel_d       = sel_q;
      stg_data_d  = stg_data_q;
      stg_dp_d    = stg_dp_q;
      stg_blank_d = stg_blank_q;
      stg_blink_d = stg_blink_q;
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      act_blink_d = act_blink_q;
      pending_d   = pending_q;
      fcnt_d      = fcnt_q;
      phase_d     = phase_q;
      an_d        = AN_OFF[NDIGITS-1:0];
      seg_d       = SEG_OFF;
      fs_d        = (sel_q == '0) && (dwell_q == '0);
      ack_d       = commit;

      if (dwell_q == DWELL_MAX) begin
         sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      end

      if (bus.load) begin
         stg_data_d  = bus.data_in;
         stg_dp_d    = bus.dp_in;
         stg_blank_d = bus.blank_in;
         stg_blink_d = bus.blink_in;
         pending_d   = 1'b1;
      end

      // A load coinciding with the boundary bypasses staging straight to active.
      if (commit) begin
         act_data_d  = bus.load ? bus.data_in  : stg_data_q;
         act_dp_d    = bus.load ? bus.dp_in    : stg_dp_q;
         act_blank_d = bus.load ? bus.blank_in : stg_blank_q;
         act_blink_d = bus.load ? bus.blink_in : stg_blink_q;
         pending_d   = 1'b0;
      end

      if (boundary) begin
         if (fcnt_q == FCNT_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
         end
      end

      if (digit_on) begin
         seg_d = ~{cur_dp, cur_pat};
         for (int i = 0; i < NDIGITS; i++) begin
            an_d[i] = ~(SEL_W'(i) == sel_q);
         end
      end
   end

   always_ff @(posedge led_clk) begin
      if (rst) begin
         sel_q       <= '0;
         dwell_q     <= '0;
         stg_data_q  <= '0;
         stg_dp_q    <= '0;
         stg_blank_q <= '0;
         stg_blink_q <= '0;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         act_blank_q <= '0;
         act_blink_q <= '0;
         pending_q   <= 1'b0;
         fcnt_q      <= '0;
         phase_q     <= 1'b0;
         an_q        <= AN_OFF[NDIGITS-1:0];
         seg_q       <= SEG_OFF;
         fs_q        <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         dwell_q     <= dwell_d;
         stg_data_q  <= stg_data_d;
         stg_dp_q    <= stg_dp_d;
         stg_blank_q <= stg_blank_d;
         stg_blink_q <= stg_blink_d;
         act_data_q  <= act_data_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
         act_blink_q <= act_blink_d;
         pending_q   <= pending_d;
         fcnt_q      <= fcnt_d;
         phase_q     <= phase_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         fs_q        <= fs_d;
         ack_q       <= ack_d;
      end
   end

   assign AN           = an_q;
   assign SEG          = seg_q;
   assign frame_start  = fs_q;
   assign bus.load_ack = ack_q;

endmodule
